// File: rtl/filter_pkg.sv
// Shared types and constants for the 3x3 filter MAC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package filter_pkg;

  localparam int WIN_DIM  = 3;
  localparam int WIN_SIZE = WIN_DIM * WIN_DIM;

  // Centre tap of the window; the identity kernel has a single 1 here.
  localparam int IDENTITY_TAP = WIN_SIZE / 2;

  typedef logic [7:0]        pixel_t;
  typedef logic signed [7:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Identity-kernel coefficient for window position idx.
  function automatic coeff_t identity_coeff(input int idx);
    return (idx == IDENTITY_TAP) ? 8'sd1 : 8'sd0;
  endfunction

endpackage

// File: rtl/filter_mac_ctrl_if.sv
// Column stream in, MAC operand/result, and result stream out of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready and out_valid/out_ready handshakes.
interface filter_mac_ctrl_if;
  import filter_pkg::*;

  logic           in_valid;
  logic           in_ready;
  pixel_t [2:0]   in_col;
  pixel_t         mac_pixels [WIN_SIZE];
  coeff_t         mac_coeffs [WIN_SIZE];
  pixel_t         mac_result;
  logic           out_valid;
  logic           out_ready;
  pixel_t         out_pixel;
  logic           out_last;

  // Sequencer side.
  modport master (
    input  in_valid, in_col, mac_result, out_ready,
    output in_ready, mac_pixels, mac_coeffs, out_valid, out_pixel, out_last
  );

  // Fetch / MAC / writeback side.
  modport slave (
    output in_valid, in_col, mac_result, out_ready,
    input  in_ready, mac_pixels, mac_coeffs, out_valid, out_pixel, out_last
  );

endinterface

// File: rtl/filter_out_fifo.sv
// Synchronous result FIFO holding {last, pixel}; head is visible combinationally.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module filter_out_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic                       head_vld_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign do_pop     = pop_i && (cnt_q != '0);
  assign do_push    = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q];
  assign head_vld_o = (cnt_q != '0);
  assign count_o    = cnt_q;

  // Storage, pointers and occupancy; simultaneous push and pop both take effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/filter_mac_ctrl.sv
// Builds sliding 3x3 windows from a column stream, feeds the MAC, queues clamped results.
// Latency: 3 cycles from accepting a window-completing column to out_valid.
// Backpressure: in_ready drops once FIFO entries plus in-flight MAC results reach OUT_DEPTH.
module filter_mac_ctrl
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  coeff_t            cfg_coeff,
  input  logic              start,
  output logic              busy,
  output logic              done,
  filter_mac_ctrl_if.master bus
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int OW = $clog2(IMG_WIDTH);
  localparam int FW = $clog2(OUT_DEPTH + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_WIDTH - 1);
  localparam logic [OW-1:0] OUT_TOTAL = OW'(IMG_WIDTH - 2);

  state_t        state_q, state_d;
  logic [CW-1:0] col_cnt_q, col_nxt;
  logic [OW-1:0] pop_cnt_q;
  pixel_t        win_q   [WIN_SIZE];
  coeff_t        coeff_q [WIN_SIZE];
  logic          p1_q, p2_q, p1_last_q, p2_last_q;
  logic          col_acc, res_pop, fifo_vld;
  logic [FW-1:0] fifo_cnt;
  logic [FW:0]   inflight;
  logic [8:0]    fifo_head;

  assign col_acc = bus.in_valid && bus.in_ready;
  assign col_nxt = col_cnt_q + CW'(1);
  assign res_pop = fifo_vld && bus.out_ready;

  assign bus.mac_pixels = win_q;
  assign bus.mac_coeffs = coeff_q;
  assign bus.out_valid  = fifo_vld;
  assign bus.out_pixel  = fifo_head[7:0];
  assign bus.out_last   = fifo_head[8];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: band runs until the last column, then drains until every result is consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (col_acc && (col_cnt_q == LAST_COL)) state_d = DRAIN;
      DRAIN:   if (!p1_q && !p2_q && !fifo_vld && (pop_cnt_q == OUT_TOTAL)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: column credit counts queued plus in-flight results, with no same-cycle pop credit.
  always_comb begin
    inflight     = (FW+1)'(fifo_cnt) + (FW+1)'(p1_q) + (FW+1)'(p2_q);
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    bus.in_ready = (state_q == RUN) && (inflight < (FW+1)'(OUT_DEPTH));
  end

  // Column and popped-result counters, cleared when a band starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      col_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else begin
      if (col_acc) col_cnt_q <= col_nxt;
      if (res_pop) pop_cnt_q <= pop_cnt_q + OW'(1);
    end
  end

  // Window shift on each accepted column; column 0 of each row is the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_SIZE; i++) win_q[i] <= '0;
    end else if (col_acc) begin
      for (int r = 0; r < WIN_DIM; r++) begin
        win_q[r*WIN_DIM]     <= win_q[r*WIN_DIM + 1];
        win_q[r*WIN_DIM + 1] <= win_q[r*WIN_DIM + 2];
        win_q[r*WIN_DIM + 2] <= bus.in_col[r];
      end
    end
  end

  // Valid/last flags shadowing the MAC register; only full windows (>= 3 columns) count.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q      <= 1'b0;
      p2_q      <= 1'b0;
      p1_last_q <= 1'b0;
      p2_last_q <= 1'b0;
    end else begin
      p1_q      <= col_acc && (col_nxt >= CW'(WIN_DIM));
      p1_last_q <= col_acc && (col_nxt == CW'(IMG_WIDTH));
      p2_q      <= p1_q;
      p2_last_q <= p1_last_q;
    end
  end

  // Coefficient bank: identity after reset, writable only while idle, out-of-range index ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_SIZE; i++) coeff_q[i] <= identity_coeff(i);
    end else if ((state_q == IDLE) && cfg_we && (cfg_idx < 4'(WIN_SIZE))) begin
      coeff_q[cfg_idx] <= cfg_coeff;
    end
  end

  filter_out_fifo #(
    .WIDTH (9),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (p2_q),
    .push_dat_i ({p2_last_q, bus.mac_result}),
    .pop_i      (res_pop),
    .head_dat_o (fifo_head),
    .head_vld_o (fifo_vld),
    .count_o    (fifo_cnt)
  );

endmodule

// File: tb/tb_filter_mac_ctrl.sv
// Directed bench for filter_mac_ctrl with a registered clamping MAC model.
// Latency: n/a.
// Backpressure: out_ready driven by the directed sequence.
module tb_filter_mac_ctrl;
  import filter_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start;
  logic [3:0] cfg_idx;
  coeff_t     cfg_coeff;
  logic       busy, done;

  int tests = 0;
  int fails = 0;

  filter_mac_ctrl_if bus ();

  filter_mac_ctrl #(
    .IMG_WIDTH (W),
    .OUT_DEPTH (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_coeff (cfg_coeff),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // External MAC: sum of products, clamped to 0..255, one register stage.
  int mac_sum;
  always_comb begin
    mac_sum = 0;
    for (int i = 0; i < WIN_SIZE; i++)
      mac_sum += int'(bus.mac_pixels[i]) * int'(bus.mac_coeffs[i]);
  end
  always @(posedge clk)
    bus.mac_result <= (mac_sum < 0) ? 8'd0 : (mac_sum > 255) ? 8'd255 : mac_sum[7:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records popped results and per-band statistics at the falling edge.
  pixel_t got_pix[$];
  logic   got_last[$];
  int n_done = 0, band_cols = 0, band_pops = 0, max_out = 0, t_acc = -1, t_first = -1, outst;
  bit saw_stall = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst || (start && !busy)) begin
      band_cols = 0; band_pops = 0; max_out = 0; t_acc = -1; t_first = -1; saw_stall = 1'b0;
    end
    if (!rst) begin
      if (done) n_done++;
      if (busy && bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      if (bus.in_valid && bus.in_ready) begin
        if (band_cols == 2) t_acc = cyc;
        band_cols++;
      end
      if (bus.out_valid && (t_first < 0)) t_first = cyc;
      if (bus.out_valid && bus.out_ready) begin
        got_pix.push_back(bus.out_pixel);
        got_last.push_back(bus.out_last);
        band_pops++;
      end
      outst = ((band_cols > 2) ? band_cols - 2 : 0) - band_pops;
      if (outst > max_out) max_out = outst;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_coeff(input int idx, input coeff_t val);
    cfg_we    = 1'b1;
    cfg_idx   = 4'(idx);
    cfg_coeff = val;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Feeds n columns; pixel(row r, column j) = a + b*r + c*j.
  task automatic feed(input int n, input int a, input int b, input int c, output int cycles);
    bit ok;
    bit all_ok;
    cycles = 0;
    all_ok = 1'b1;
    for (int j = 0; j < n; j++) begin
      bus.in_valid = 1'b1;
      for (int r = 0; r < 3; r++) bus.in_col[r] = pixel_t'(a + b*r + c*j);
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        cycles++;
      end
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    chk("feed_accepted", all_ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200 && busy; k++) tick();
    chk({tag, "_idle_timeout"}, busy, 0);
  endtask

  task automatic run_band(input string tag, input int a, input int b, input int c, output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(W, a, b, c, cycles);
    wait_idle(tag);
  endtask

  task automatic check_band(input string tag, input int base, input int nd0, input int e0, input int de);
    chk({tag, "_count"}, got_pix.size() - base, W - 2);
    for (int k = 0; k < W - 2; k++) begin
      if (base + k < got_pix.size()) begin
        chk({tag, "_pix"}, got_pix[base+k], e0 + de*k);
        chk({tag, "_last"}, got_last[base+k], (k == W - 3));
      end
    end
    chk({tag, "_done_pulses"}, n_done - nd0, 1);
    chk({tag, "_busy_low"}, busy, 0);
  endtask

  int base, nd, cycles;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_coeff = '0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_col = '0; bus.out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_pixel", bus.out_pixel, 0);
    chk("rst_coeff4", bus.mac_coeffs[4], 1);
    chk("rst_coeff0", bus.mac_coeffs[0], 0);
    chk("rst_win4", bus.mac_pixels[4], 0);
    rst = 1'b0;
    tick();

    // Identity kernel, column j = (j, 16+j, 32+j): results 17..22 at full rate
    base = got_pix.size(); nd = n_done;
    run_band("ident", 0, 16, 1, cycles);
    chk("ident_feed_cycles", cycles, W);
    check_band("ident", base, nd, 17, 1);
    chk("ident_latency", t_first - t_acc, 3);

    // All-ones kernel with pixels 30 saturates at 255
    for (int i = 0; i < WIN_SIZE; i++) set_coeff(i, 8'sd1);
    chk("ones_coeff0", bus.mac_coeffs[0], 1);
    chk("ones_coeff8", bus.mac_coeffs[8], 1);
    base = got_pix.size(); nd = n_done;
    run_band("sat", 30, 0, 0, cycles);
    check_band("sat", base, nd, 255, 0);

    // All -1 kernel with pixels 10 clamps at 0
    for (int i = 0; i < WIN_SIZE; i++) set_coeff(i, -8'sd1);
    chk("neg_coeff3", bus.mac_coeffs[3], -1);
    base = got_pix.size(); nd = n_done;
    run_band("neg", 10, 0, 0, cycles);
    check_band("neg", base, nd, 0, 0);

    // Back to identity, then stall the output for 12 cycles mid-band
    for (int i = 0; i < WIN_SIZE; i++) set_coeff(i, (i == 4) ? 8'sd1 : 8'sd0);
    base = got_pix.size(); nd = n_done;
    fork
      run_band("stall", 0, 16, 1, cycles);
      begin
        repeat (3) tick();
        bus.out_ready = 1'b0;
        repeat (12) tick();
        bus.out_ready = 1'b1;
      end
    join
    chk("stall_in_ready_dropped", saw_stall, 1);
    chk("stall_max_outstanding", max_out, D);
    check_band("stall", base, nd, 17, 1);

    // Out-of-range index in IDLE, then a write and a start while running: all ignored
    set_coeff(9, 8'sd7);
    for (int i = 0; i < WIN_SIZE; i++) chk("idx9_coeff", bus.mac_coeffs[i], (i == 4) ? 1 : 0);
    base = got_pix.size(); nd = n_done;
    fork
      run_band("ignored", 0, 16, 1, cycles);
      begin
        repeat (4) tick();
        cfg_we = 1'b1; cfg_idx = 4'd4; cfg_coeff = 8'sd5;
        tick();
        cfg_we = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
      end
    join
    chk("run_write_coeff4", bus.mac_coeffs[4], 1);
    check_band("ignored", base, nd, 17, 1);
    repeat (3) tick();
    chk("busy_start_no_rerun", busy, 0);

    // Reset after 4 columns with results buffered
    set_coeff(0, 8'sd3);
    chk("pre_rst_coeff0", bus.mac_coeffs[0], 3);
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(4, 0, 16, 1, cycles);
    repeat (2) tick();
    chk("pre_rst_out_valid", bus.out_valid, 1);
    rst = 1'b1;
    tick();
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_coeff0", bus.mac_coeffs[0], 0);
    chk("post_rst_coeff4", bus.mac_coeffs[4], 1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    base = got_pix.size(); nd = n_done;
    run_band("fresh", 0, 16, 1, cycles);
    check_band("fresh", base, nd, 17, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
